// File: rtl/worley_noise_pipe.sv
// rtl/worley_noise_pipe.sv - animated feature points and 3-stage Worley noise pipeline
module worley_noise_pipe #(
   parameter int NUM_POINTS = 4,
   parameter int COORD_W    = 10,
   parameter int VEL_W      = 4,
   parameter int H_LIMIT    = 639,
   parameter int V_LIMIT    = 479,
   parameter int OUT_W      = 8,
   parameter int DIST_SHIFT = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      frame_tick,
   input  logic                      cfg_we,
   input  logic [2:0]                cfg_idx,
   input  logic [COORD_W-1:0]        cfg_x,
   input  logic [COORD_W-1:0]        cfg_y,
   input  logic signed [VEL_W-1:0]   cfg_vx,
   input  logic signed [VEL_W-1:0]   cfg_vy,
   input  logic                      mode,
   input  logic                      pix_valid,
   input  logic [COORD_W-1:0]        pix_x,
   input  logic [COORD_W-1:0]        pix_y,
   output logic                      noise_valid,
   output logic [OUT_W-1:0]          noise,
   output logic [2:0]                nearest_idx
);

   // squared distance holds dx^2 + dy^2 without truncation
   localparam int DW = 2 * COORD_W + 1;
   // signed step arithmetic needs one bit more than a coordinate
   localparam int SW = COORD_W + 1;
   localparam logic [DW-1:0] SAT = DW'((1 << OUT_W) - 1);

   // One axis of motion: step by v, clamp to [0, lim] and reverse on contact.
   function automatic logic [COORD_W+VEL_W-1:0] f_step(
      input logic [COORD_W-1:0]      p,
      input logic signed [VEL_W-1:0] v,
      input int                      lim
   );
      logic signed [SW-1:0] n;
      logic signed [SW-1:0] l;
      n = $signed({1'b0, p}) + SW'(v);
      l = SW'(lim);
      if (n[SW-1])
         return {{COORD_W{1'b0}}, -v};
      else if (n > l)
         return {COORD_W'(lim), -v};
      else
         return {n[COORD_W-1:0], v};
   endfunction

   logic [COORD_W-1:0]        r_px [NUM_POINTS];
   logic [COORD_W-1:0]        r_py [NUM_POINTS];
   logic signed [VEL_W-1:0]   r_vx [NUM_POINTS];
   logic signed [VEL_W-1:0]   r_vy [NUM_POINTS];

   logic [COORD_W-1:0]        r_dx [NUM_POINTS];
   logic [COORD_W-1:0]        r_dy [NUM_POINTS];
   logic                      r_v1;
   logic                      r_m1;

   logic [DW-1:0]             r_d [NUM_POINTS];
   logic                      r_v2;
   logic                      r_m2;

   logic [DW-1:0]             w_f1;
   logic [DW-1:0]             w_f2;
   logic [2:0]                w_idx;
   logic [DW-1:0]             w_sh;
   logic [OUT_W-1:0]          w_s;
   logic [OUT_W-1:0]          w_noise;

   // point state: spread along the centre line at reset, then cfg write or per-frame step
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_POINTS; i++) begin
         if (reset) begin
            r_px[i] <= COORD_W'((2 * i + 1) * (H_LIMIT + 1) / (2 * NUM_POINTS));
            r_py[i] <= COORD_W'((V_LIMIT + 1) / 2);
            r_vx[i] <= VEL_W'(1);
            r_vy[i] <= (i % 2 == 0) ? VEL_W'(1) : VEL_W'(-1);
         end else if (cfg_we && int'(cfg_idx) == i) begin
            r_px[i] <= cfg_x;
            r_py[i] <= cfg_y;
            r_vx[i] <= cfg_vx;
            r_vy[i] <= cfg_vy;
         end else if (frame_tick) begin
            {r_px[i], r_vx[i]} <= f_step(r_px[i], r_vx[i], H_LIMIT);
            {r_py[i], r_vy[i]} <= f_step(r_py[i], r_vy[i], V_LIMIT);
         end
      end
   end

   // S1: per-point absolute coordinate differences, mode travels with the pixel
   always_ff @(posedge clk) begin
      if (reset)
         r_v1 <= 1'b0;
      else
         r_v1 <= pix_valid;
      r_m1 <= mode;
      for (int i = 0; i < NUM_POINTS; i++) begin
         r_dx[i] <= (pix_x >= r_px[i]) ? pix_x - r_px[i] : r_px[i] - pix_x;
         r_dy[i] <= (pix_y >= r_py[i]) ? pix_y - r_py[i] : r_py[i] - pix_y;
      end
   end

   // S2: full-width squared distances
   always_ff @(posedge clk) begin
      if (reset)
         r_v2 <= 1'b0;
      else
         r_v2 <= r_v1;
      r_m2 <= r_m1;
      for (int i = 0; i < NUM_POINTS; i++)
         r_d[i] <= DW'(r_dx[i]) * DW'(r_dx[i]) + DW'(r_dy[i]) * DW'(r_dy[i]);
   end

   // S3 combinational: smallest two distances (strict compare keeps lowest index on ties) and shaping
   always_comb begin
      w_f1  = '1;
      w_f2  = '1;
      w_idx = '0;
      for (int i = 0; i < NUM_POINTS; i++) begin
         if (r_d[i] < w_f1) begin
            w_f2  = w_f1;
            w_f1  = r_d[i];
            w_idx = 3'(i);
         end else if (r_d[i] < w_f2) begin
            w_f2 = r_d[i];
         end
      end
      w_sh    = r_m2 ? (w_f2 - w_f1) >> DIST_SHIFT : w_f1 >> DIST_SHIFT;
      w_s     = (w_sh > SAT) ? '1 : w_sh[OUT_W-1:0];
      w_noise = r_m2 ? w_s : ~w_s;
   end

   // S3 output register; idle slots present zeros
   always_ff @(posedge clk) begin
      if (reset) begin
         noise_valid <= 1'b0;
         noise       <= '0;
         nearest_idx <= '0;
      end else begin
         noise_valid <= r_v2;
         noise       <= r_v2 ? w_noise : '0;
         nearest_idx <= r_v2 ? w_idx : '0;
      end
   end

endmodule
